// File: rtl/onchip_mem_avalon_bridge.sv
`timescale 1ns/1ps
// Avalon-MM slave front-end for single-port on-chip RAM: a small command FIFO issues at most one command per cycle.
// Optional macro ONCHIP_BRIDGE_RDREG_EN registers s_readdata/s_readdatavalid, which adds one cycle of read latency.
module onchip_mem_avalon_bridge #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [DATA_W-1:0]     s_writedata,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_clken,
  input  logic [DATA_W-1:0]     m_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fifoAddr  [DEPTH];
  logic [BE_W-1:0]   r_fifoBe    [DEPTH];
  logic [DATA_W-1:0] r_fifoData  [DEPTH];
  logic              r_fifoWrite [DEPTH];

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rdPending;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_headWrite;

  // Waitrequest depends on registered count only, so it stays high when full even if a pop happens this cycle.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = (s_read | s_write) & ~w_full;
  assign w_pop       = ~w_empty & ~hold;
  assign w_headWrite = r_fifoWrite[r_rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifoAddr[i]  <= '0;
        r_fifoBe[i]    <= '0;
        r_fifoData[i]  <= '0;
        r_fifoWrite[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_fifoAddr[r_wrPtr]  <= s_address;
      r_fifoBe[r_wrPtr]    <= s_byteenable;
      r_fifoData[r_wrPtr]  <= s_writedata;
      r_fifoWrite[r_wrPtr] <= s_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Keeps advancing under hold: the frozen RAM keeps m_readdata stable for the read already issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPending <= 1'b0;
    end else begin
      r_rdPending <= w_pop & ~w_headWrite;
    end
  end

  assign s_waitrequest = w_full;
  assign m_chipselect  = w_pop;
  assign m_write       = w_pop & w_headWrite;
  assign m_address     = w_empty ? '0 : r_fifoAddr[r_rdPtr];
  assign m_byteenable  = w_empty ? '0 : r_fifoBe[r_rdPtr];
  assign m_writedata   = w_empty ? '0 : r_fifoData[r_rdPtr];
  assign m_clken       = ~hold;

`ifdef ONCHIP_BRIDGE_RDREG_EN
  logic              r_rdValid;
  logic [DATA_W-1:0] r_rdData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= r_rdPending;
      if (r_rdPending) begin
        r_rdData <= m_readdata;
      end
    end
  end

  assign s_readdatavalid = r_rdValid;
  assign s_readdata      = r_rdData;
`else
  assign s_readdatavalid = r_rdPending;
  assign s_readdata      = r_rdPending ? m_readdata : '0;
`endif

endmodule

// File: tb/tb_onchip_mem_avalon_bridge.sv
`timescale 1ns/1ps
// Randomized and directed bench for onchip_mem_avalon_bridge against a queue-based reference model.
// Build with ONCHIP_BRIDGE_RDREG_EN defined to check the registered read-return variant.
module tb_onchip_mem_avalon_bridge;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int BE_W   = DATA_W / 8;
`ifdef ONCHIP_BRIDGE_RDREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] s_address = '0;
  logic [BE_W-1:0]   s_byteenable = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [DATA_W-1:0] s_writedata = '0;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  onchip_mem_avalon_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
    .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with a registered output that freezes when m_clken is low.
  logic [DATA_W-1:0] ramArray [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ramOut = '0;
  assign m_readdata = ramOut;

  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      if (m_write) begin
        for (int i = 0; i < BE_W; i++) begin
          if (m_byteenable[i]) ramArray[m_address][8*i +: 8] <= m_writedata[8*i +: 8];
        end
      end else begin
        ramOut <= ramArray[m_address];
      end
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
    logic              isWrite;
  } cmd_t;

  typedef struct packed {
    int                due;
    logic [DATA_W-1:0] data;
  } rd_t;

  cmd_t              cmdQ [$];
  rd_t               rdQ [$];
  logic [DATA_W-1:0] refMem [0:(1<<ADDR_W)-1];
  int                cyc = 0;
  int                checks = 0;
  int                passes = 0;
  int                validCount = 0;
  int                lastValidCyc = 0;
  logic [DATA_W-1:0] lastValidData = '0;
  logic [DATA_W-1:0] lastRd = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  // One clock of stimulus; compares outputs with the model, then advances the model across the edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [BE_W-1:0] be, input logic [DATA_W-1:0] data,
                               input logic hl, output logic accepted);
    logic modelFull;
    logic doPop;
    logic expValid;
    cmd_t c;
    s_read = rd; s_write = wr; s_address = addr; s_byteenable = be; s_writedata = data; hold = hl;
    #1;
    modelFull = (cmdQ.size() == DEPTH);
    doPop = (cmdQ.size() > 0) && !hl;
    checkOutput("waitrequest", s_waitrequest, modelFull);
    checkOutput("chipselect", m_chipselect, doPop);
    checkOutput("clken", m_clken, !hl);
    if (cmdQ.size() > 0) begin
      checkOutput("m_write", m_write, doPop && cmdQ[0].isWrite);
      checkOutput("m_address", m_address, cmdQ[0].addr);
      checkOutput("m_byteenable", m_byteenable, cmdQ[0].be);
      checkOutput("m_writedata", m_writedata, cmdQ[0].data);
    end else begin
      checkOutput("m_write_idle", m_write, 0);
      checkOutput("m_address_idle", m_address, 0);
    end
    expValid = (rdQ.size() > 0) && (rdQ[0].due == cyc);
    checkOutput("readdatavalid", s_readdatavalid, expValid);
    if (expValid) begin
      checkOutput("readdata", s_readdata, rdQ[0].data);
      lastRd = rdQ[0].data;
      void'(rdQ.pop_front());
    end
`ifdef ONCHIP_BRIDGE_RDREG_EN
    else checkOutput("readdata_hold", s_readdata, lastRd);
`endif
    if (s_readdatavalid) begin
      validCount++;
      lastValidCyc = cyc;
      lastValidData = s_readdata;
    end
    accepted = (rd || wr) && !s_waitrequest;
    if (doPop) begin
      c = cmdQ.pop_front();
      if (c.isWrite) begin
        for (int i = 0; i < BE_W; i++) if (c.be[i]) refMem[c.addr][8*i +: 8] = c.data[8*i +: 8];
      end else begin
        rdQ.push_back('{due: cyc + RD_LAT, data: refMem[c.addr]});
      end
    end
    if ((rd || wr) && !modelFull) cmdQ.push_back('{addr: addr, be: be, data: data, isWrite: wr});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic applyReset(input logic hl);
    reset = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = '0; s_byteenable = '0;
    s_writedata = '0; hold = hl;
    #1;
    checkOutput("rst_waitrequest", s_waitrequest, 0);
    checkOutput("rst_chipselect", m_chipselect, 0);
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_m_address", m_address, 0);
    checkOutput("rst_m_byteenable", m_byteenable, 0);
    checkOutput("rst_m_writedata", m_writedata, 0);
    checkOutput("rst_readdatavalid", s_readdatavalid, 0);
    checkOutput("rst_readdata", s_readdata, 0);
    checkOutput("rst_clken", m_clken, !hl);
    cmdQ.delete();
    rdQ.delete();
    lastRd = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic hl);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, hl, acc);
  endtask

  initial begin
    logic acc;
    int   accN;
    int   v0;
    int   readCyc;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ramArray[i] = '0;
      refMem[i] = '0;
    end
    @(negedge clk);
    applyReset(1'b0);

    // Write then read back with latency measurement.
    applyStimulus(1'b0, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 1'b0, acc);
    readCyc = cyc;
    applyStimulus(1'b1, 1'b0, 12'h010, 4'h0, 32'h0, 1'b0, acc);
    idleCycles(4, 1'b0);
    checkOutput("t1_latency", lastValidCyc - readCyc, RD_LAT + 1);
    checkOutput("t1_data", lastValidData, 32'hDEADBEEF);

    // Partial byte-lane write merge.
    applyStimulus(1'b0, 1'b1, 12'h020, 4'hF, 32'h11223344, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 12'h020, 4'h5, 32'hAABBCCDD, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 12'h020, 4'h0, 32'h0, 1'b0, acc);
    idleCycles(4, 1'b0);
    checkOutput("lanes_data", lastValidData, 32'h11BB33DD);

    // Back-to-back writes then reads.
    v0 = validCount;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, ADDR_W'(i), 4'hF, 32'h1000 + i, 1'b0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, ADDR_W'(i), 4'h0, 32'h0, 1'b0, acc);
    idleCycles(4, 1'b0);
    checkOutput("b2b_valids", validCount - v0, 4);
    checkOutput("b2b_last", lastValidData, 32'h1003);

    // Queue six reads under hold: four fit, then backpressure until release.
    v0 = validCount;
    accN = 0;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b1, 1'b0, ADDR_W'(accN), 4'h0, 32'h0, 1'b1, acc);
      if (acc) accN++;
    end
    checkOutput("hold_accepts", accN, 4);
    for (int t = 0; t < 12 && accN < 6; t++) begin
      applyStimulus(1'b1, 1'b0, ADDR_W'(accN), 4'h0, 32'h0, 1'b0, acc);
      if (acc) accN++;
    end
    checkOutput("hold_total", accN, 6);
    idleCycles(8, 1'b0);
    checkOutput("hold_valids", validCount - v0, 6);

    // Read and write together: write wins, no read return.
    v0 = validCount;
    applyStimulus(1'b1, 1'b1, 12'h030, 4'hF, 32'h5A5A5A5A, 1'b0, acc);
    idleCycles(4, 1'b0);
    checkOutput("rw_novalid", validCount - v0, 0);
    checkOutput("rw_mem", ramArray[12'h030], 32'h5A5A5A5A);
    applyStimulus(1'b1, 1'b0, 12'h030, 4'h0, 32'h0, 1'b0, acc);
    idleCycles(4, 1'b0);
    checkOutput("rw_readback", lastValidData, 32'h5A5A5A5A);

    // Reset with three reads queued under hold.
    v0 = validCount;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, ADDR_W'(i), 4'h0, 32'h0, 1'b1, acc);
    applyReset(1'b1);
    idleCycles(6, 1'b0);
    checkOutput("rst_novalid", validCount - v0, 0);

    // Randomized traffic with hold bursts and one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      logic rd, wr, hl;
      if (i == 200) applyReset(1'($urandom_range(0, 1)));
      rd = ($urandom_range(0, 99) < 45);
      wr = ($urandom_range(0, 99) < 40);
      hl = ((i % 60) >= 50) || ($urandom_range(0, 9) == 0);
      applyStimulus(rd, wr, ADDR_W'(12'h100 + $urandom_range(0, 15)), BE_W'($urandom_range(0, 15)),
                    DATA_W'($urandom), hl, acc);
    end
    idleCycles(8, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_avalon_bridge.md
# onchip_mem_avalon_bridge

Pipelined Avalon-MM slave front-end for the Nios II on-chip RAM. It accepts read and write commands from the system interconnect and buffers them in a small command FIFO. It issues at most one command per cycle to the single-port on-chip memory and returns read data with `s_readdatavalid`. A `hold` input freezes the memory clock enable and command issue; the FIFO absorbs traffic while `hold` is high.

## Interface
- `ADDR_W`, 12: word address width, matching the 4096-word memory.
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.
- `DEPTH`, 4: command FIFO depth; must be a power of two and ≥2.

Ports:
- `clk`  in  1  single clock for the block and the memory.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `hold`  in  1  freeze request; when high, no command is issued and `m_clken`=0.
- `s_address`  in  ADDR_W  word address.
- `s_byteenable`  in  DATA_W/8  write byte lanes.
- `s_read`  in  1  read request.
- `s_write`  in  1  write request.
- `s_writedata`  in  DATA_W  write data.
- `s_waitrequest`  out  1  command not accepted this cycle.
- `s_readdata`  out  DATA_W  read data.
- `s_readdatavalid`  out  1  `s_readdata` is valid this cycle.
- `m_address`  out  ADDR_W  address to the memory.
- `m_byteenable`  out  DATA_W/8  byte lanes to the memory.
- `m_chipselect`  out  1  a command is issued this cycle.
- `m_write`  out  1  the issued command is a write.
- `m_writedata`  out  DATA_W  write data to the memory.
- `m_clken`  out  1  memory clock enable, `~hold`.
- `m_readdata`  in  DATA_W  memory output; valid the cycle after a read is issued.

## Operation
- Accept: `(s_read|s_write) & ~s_waitrequest` at a rising edge pushes {addr, be, wdata, is_write} into the FIFO.
- `s_read` and `s_write` both high: treated as a write; the read is dropped.
- `s_waitrequest` = (count == DEPTH). It is derived from registered state only. It stays asserted when full even if a pop occurs in the same cycle.
- Issue: when count>0 and `hold`=0, the FIFO head drives `m_*` with `m_chipselect`=1, and the entry pops at the edge. Otherwise `m_chipselect`=0 and `m_write`=0.
- `m_address`, `m_byteenable` and `m_writedata` show the FIFO head, or zeros when the FIFO is empty.
- Ordering: commands issue strictly in acceptance order. A read issued the cycle after a write to the same address returns the new data.
- Read return: a 1-bit shift register tracks each issued read. It keeps advancing while `hold`=1, because the memory address register is frozen and `m_readdata` stays stable.
- Count arithmetic: simultaneous push and pop leaves count unchanged. The FIFO pointers are `log2(DEPTH)` bits and wrap modulo DEPTH.
- Reset value of all outputs is 0 except `m_clken`, which follows `~hold`. Reset mid-operation discards queued commands and in-flight reads; no `s_readdatavalid` is produced for them.

## Timing
- A command accepted at edge N issues during cycle N+1 at the earliest, when `hold`=0 and the FIFO was empty.
- Read accepted at edge N: `s_readdatavalid`=1 during cycle N+2, with `s_readdata` = `m_readdata`.
- Throughput: one command per cycle sustained; the FIFO occupancy stays ≤1 when `hold`=0.
- A `hold` asserted for H cycles delays issue by H cycles. Up to DEPTH commands queue during that time, after which `s_waitrequest` rises.
- `s_readdatavalid` pulses are one cycle each and appear in issue order.

## Configuration
- `ONCHIP_BRIDGE_RDREG_EN` defined: `s_readdata` and `s_readdatavalid` are registered, so read latency from acceptance is 3 cycles. `s_readdata` holds its last value when `s_readdatavalid`=0.
- Undefined: `s_readdata` is combinational from `m_readdata`, giving a latency of 2 cycles. `s_readdata` is don't-care when `s_readdatavalid`=0.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x010 with be=0xF, then read 0x010. Expect `s_readdatavalid` 2 cycles after the read is accepted (3 with RDREG) and data 0xDEADBEEF.
- Byte lanes: write 0x11223344 to 0x020 with be=0xF, then write 0xAABBCCDD to 0x020 with be=0x5, then read 0x020. Expect 0x11BB33DD.
- Back-to-back: writes to 0x000–0x003 on consecutive cycles, followed immediately by reads of 0x000–0x003. Expect no waitrequest and four consecutive valids returning the written data in order.
- Hold: `hold`=1, then issue 6 reads. Expect `s_waitrequest` to rise after 4 accepts and `m_chipselect`=0 throughout. Release `hold` and expect 6 valids in order.
- Read and write both asserted for address 0x030 with data 0x5A5A5A5A. Expect the memory to be written with 0x5A5A5A5A and no `s_readdatavalid`.
- Assert `reset` while 3 reads are queued under `hold`. Expect all outputs 0, no valids after release, and count = 0.
